// File: rtl/ryuki_datatypes.sv
// Shared trace datatypes plus the trace stream arbiter's index type and FSM encoding.
package ryuki_datatypes;

  // One retired-stage record emitted by a pipeline tracker.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [15:0] time_start;
    logic [15:0] time_end;
  } trace_output;

  localparam int unsigned TRACE_ARB_MAX_SRC = 8;
  localparam int unsigned TRACE_ARB_IDX_W   = $clog2(TRACE_ARB_MAX_SRC);

  typedef logic [TRACE_ARB_IDX_W-1:0] src_idx_t;

  typedef enum logic {
    ARB_IDLE    = 1'b0,
    ARB_PRESENT = 1'b1
  } arb_state_e;

  // Width of a source index for n sources, never less than one bit.
  function automatic int unsigned src_idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/trace_stream_arbiter_if.sv
// Merged trace record stream toward the trace buffer writer.
interface trace_stream_arbiter_if #(
  parameter int unsigned SRC_W = 2
);
  logic                       out_valid_o;
  ryuki_datatypes::trace_output out_data_o;
  logic [SRC_W-1:0]           out_src_o;
  logic                       out_ready_i;

  modport master (output out_valid_o, out_data_o, out_src_o, input out_ready_i);
  modport slave  (input out_valid_o, out_data_o, out_src_o, output out_ready_i);
endinterface

// File: rtl/trace_record_fifo.sv
// Single-clock trace record FIFO with extra-MSB pointers for full/empty.
module trace_record_fifo
  import ryuki_datatypes::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        push_i,
  input  trace_output data_i,
  input  logic        pop_i,
  output trace_output data_c,
  output logic        full_c,
  output logic        empty_c
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  trace_output   mem_q [DEPTH];
  trace_output   mem_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;

  // Write at the write pointer, advance pointers on push/pop.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_i) begin
      mem_d[wr_ptr_q[AW-1:0]] = data_i;
      wr_ptr_d                = wr_ptr_q + PW'(1);
    end
    if (pop_i) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
  end

  // Storage and pointer registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  assign data_c  = mem_q[rd_ptr_q[AW-1:0]];
  assign empty_c = (wr_ptr_q == rd_ptr_q);
  assign full_c  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

endmodule

// File: rtl/trace_stream_arbiter.sv
// Merges edge-captured tracker records through per-source FIFOs into one round-robin stream.
module trace_stream_arbiter
  import ryuki_datatypes::*;
#(
  parameter int unsigned NUM_SRC    = 3,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          enable_i,
  input  logic        [NUM_SRC-1:0]     src_valid_i,
  input  trace_output [NUM_SRC-1:0]     src_data_i,
  trace_stream_arbiter_if.master        out_if,
  output logic [CNT_WIDTH*NUM_SRC-1:0]  drop_count_o,
  output logic                          overflow_o,
  input  logic                          clr_overflow_i
);

  localparam int unsigned SRC_W = src_idx_width(NUM_SRC);

  logic [NUM_SRC-1:0]   src_valid_q, src_valid_d;
  logic [NUM_SRC-1:0]   cap_c, push_c, drop_c, pop_c;
  logic [NUM_SRC-1:0]   fifo_full_c, fifo_empty_c;
  trace_output          fifo_data_c [NUM_SRC];

  src_idx_t             rr_ptr_q, rr_ptr_d;
  src_idx_t             cand_c, gnt_idx_c;
  logic                 gnt_valid_c;
  trace_output          gnt_data_c;
  logic                 load_c;

  arb_state_e           state_q, state_d;
  logic                 out_valid_q, out_valid_d;
  trace_output          out_data_q, out_data_d;
  logic [SRC_W-1:0]     out_src_q, out_src_d;

  logic [CNT_WIDTH-1:0] cnt_q [NUM_SRC];
  logic [CNT_WIDTH-1:0] cnt_d [NUM_SRC];
  logic                 overflow_q, overflow_d;

  // One private FIFO per tracker.
  for (genvar g = 0; g < NUM_SRC; g++) begin : g_fifo
    trace_record_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (push_c[g]),
      .data_i  (src_data_i[g]),
      .pop_i   (pop_c[g]),
      .data_c  (fifo_data_c[g]),
      .full_c  (fifo_full_c[g]),
      .empty_c (fifo_empty_c[g])
    );
  end

  // Round-robin grant: first non-empty FIFO at or after rr_ptr, using pre-push state.
  always_comb begin
    gnt_valid_c = 1'b0;
    gnt_idx_c   = '0;
    gnt_data_c  = '0;
    cand_c      = '0;
    for (int unsigned k = 0; k < NUM_SRC; k++) begin
      cand_c = src_idx_t'((32'(rr_ptr_q) + k) % NUM_SRC);
      for (int unsigned i = 0; i < NUM_SRC; i++) begin
        if (!gnt_valid_c && (cand_c == src_idx_t'(i)) && !fifo_empty_c[i]) begin
          gnt_valid_c = 1'b1;
          gnt_idx_c   = cand_c;
          gnt_data_c  = fifo_data_c[i];
        end
      end
    end
  end

  // FSM next state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ARB_IDLE:    if (gnt_valid_c) state_d = ARB_PRESENT;
      ARB_PRESENT: if (out_if.out_ready_i && !gnt_valid_c) state_d = ARB_IDLE;
      default:     state_d = ARB_IDLE;
    endcase
  end

  // FSM outputs: load a granted record when the output register is free or being accepted.
  always_comb begin
    load_c      = 1'b0;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_src_d   = out_src_q;
    case (state_q)
      ARB_IDLE: begin
        out_valid_d = 1'b0;
        load_c      = gnt_valid_c;
      end
      ARB_PRESENT: begin
        if (out_if.out_ready_i) begin
          out_valid_d = 1'b0;
          load_c      = gnt_valid_c;
        end
      end
      default: out_valid_d = 1'b0;
    endcase
    if (load_c) begin
      out_valid_d = 1'b1;
      out_data_d  = gnt_data_c;
      out_src_d   = SRC_W'(gnt_idx_c);
    end
    rr_ptr_d = load_c ? src_idx_t'((32'(gnt_idx_c) + 32'd1) % NUM_SRC) : rr_ptr_q;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      pop_c[i] = load_c && (gnt_idx_c == src_idx_t'(i));
    end
  end

  // Edge capture, push/drop decision and saturating drop counters; a drop beats a clear.
  always_comb begin
    src_valid_d = src_valid_i;
    overflow_d  = clr_overflow_i ? 1'b0 : overflow_q;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      cap_c[i]  = enable_i && src_valid_i[i] && !src_valid_q[i];
      push_c[i] = cap_c[i] && (!fifo_full_c[i] || pop_c[i]);
      drop_c[i] = cap_c[i] && fifo_full_c[i] && !pop_c[i];
      cnt_d[i]  = clr_overflow_i ? '0 : cnt_q[i];
      if (drop_c[i]) begin
        overflow_d = 1'b1;
        if (cnt_d[i] != '1) begin
          cnt_d[i] = cnt_d[i] + CNT_WIDTH'(1);
        end
      end
    end
  end

  // State, output and counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ARB_IDLE;
      src_valid_q <= '0;
      rr_ptr_q    <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_src_q   <= '0;
      overflow_q  <= 1'b0;
      for (int i = 0; i < NUM_SRC; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      src_valid_q <= src_valid_d;
      rr_ptr_q    <= rr_ptr_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_src_q   <= out_src_d;
      overflow_q  <= overflow_d;
      cnt_q       <= cnt_d;
    end
  end

  // Flatten counters onto the output bus.
  always_comb begin
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      drop_count_o[i*CNT_WIDTH +: CNT_WIDTH] = cnt_q[i];
    end
  end

  assign out_if.out_valid_o = out_valid_q;
  assign out_if.out_data_o  = out_data_q;
  assign out_if.out_src_o   = out_src_q;
  assign overflow_o         = overflow_q;

endmodule

// File: tb/tb_trace_stream_arbiter.sv
// Directed bench for trace_stream_arbiter with a queue-based reference model.
module tb_trace_stream_arbiter;
  import ryuki_datatypes::*;

  localparam int unsigned NSRC  = 3;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned CW    = 16;
  localparam int unsigned SW    = 2;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   enable;
  logic [NSRC-1:0]        src_valid;
  trace_output [NSRC-1:0] src_data;
  logic [CW*NSRC-1:0]     drop_count;
  logic                   overflow;
  logic                   clr;

  trace_stream_arbiter_if #(.SRC_W(SW)) sif ();

  trace_stream_arbiter #(.NUM_SRC(NSRC), .FIFO_DEPTH(DEPTH), .CNT_WIDTH(CW)) dut (
    .clk            (clk),
    .rst            (rst),
    .enable_i       (enable),
    .src_valid_i    (src_valid),
    .src_data_i     (src_data),
    .out_if         (sif),
    .drop_count_o   (drop_count),
    .overflow_o     (overflow),
    .clr_overflow_i (clr)
  );

  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  // Reference model state
  trace_output mq [NSRC][$];
  bit          m_valid;
  trace_output m_data;
  int          m_src;
  int          m_rr;
  bit [NSRC-1:0] m_prev;
  int          m_cnt [NSRC];
  bit          m_ovf;

  // Handshakes observed on the DUT output
  int acc_cnt;
  int acc_src [$];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic trace_output rec(input int s, input int n);
    trace_output r;
    r.pc         = 32'h8000_0000 + 32'(n * 4);
    r.instr      = 32'h0000_0013 + 32'(s << 8);
    r.time_start = 16'(n);
    r.time_end   = 16'(n + s + 1);
    return r;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse(input int s, input int n);
    src_data[s]  = rec(s, n);
    src_valid[s] = 1'b1;
    tick(1);
    src_valid[s] = 1'b0;
    tick(1);
  endtask

  task automatic acc_clear();
    acc_cnt = 0;
    acc_src.delete();
  endtask

  // Model: output register fed from per-source queues, round-robin, drops when a queue is full.
  initial begin
    int g;
    int c;
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        for (int i = 0; i < NSRC; i++) begin
          mq[i].delete();
          m_cnt[i] = 0;
        end
        m_valid = 1'b0;
        m_data  = '0;
        m_src   = 0;
        m_rr    = 0;
        m_prev  = '0;
        m_ovf   = 1'b0;
      end else begin
        if (sif.out_valid_o && sif.out_ready_i) begin
          acc_cnt++;
          acc_src.push_back(int'(sif.out_src_o));
        end
        if (!m_valid || sif.out_ready_i) begin
          g = -1;
          for (int k = 0; k < NSRC; k++) begin
            c = (m_rr + k) % NSRC;
            if (g < 0 && mq[c].size() > 0) g = c;
          end
          if (g >= 0) begin
            m_data  = mq[g].pop_front();
            m_src   = g;
            m_valid = 1'b1;
            m_rr    = (g + 1) % NSRC;
          end else begin
            m_valid = 1'b0;
          end
        end
        if (clr) begin
          for (int i = 0; i < NSRC; i++) m_cnt[i] = 0;
          m_ovf = 1'b0;
        end
        for (int i = 0; i < NSRC; i++) begin
          if (enable && src_valid[i] && !m_prev[i]) begin
            if (mq[i].size() < DEPTH) begin
              mq[i].push_back(src_data[i]);
            end else begin
              if (m_cnt[i] < (1 << CW) - 1) m_cnt[i]++;
              m_ovf = 1'b1;
            end
          end
        end
        m_prev = src_valid;
      end
    end
  end

  // Per-cycle compare of DUT outputs against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (chk_en && !rst) begin
        check("out_valid", sif.out_valid_o, m_valid);
        if (m_valid) begin
          check("out_src", sif.out_src_o, m_src);
          check("out_data", sif.out_data_o, m_data);
        end
        for (int i = 0; i < NSRC; i++) begin
          check("drop_count", drop_count[i*CW +: CW], m_cnt[i]);
        end
        check("overflow", overflow, m_ovf);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    trace_output exp_rec;
    rst             = 1'b1;
    enable          = 1'b1;
    src_valid       = '0;
    src_data        = '0;
    clr             = 1'b0;
    sif.out_ready_i = 1'b0;
    acc_clear();
    tick(2);
    check("rst_out_valid", sif.out_valid_o, 1'b0);
    check("rst_out_src", sif.out_src_o, 0);
    check("rst_out_data", sif.out_data_o, 0);
    check("rst_drop_count", drop_count, 0);
    check("rst_overflow", overflow, 1'b0);
    rst    = 1'b0;
    chk_en = 1'b1;
    tick(2);

    // Round-robin from pointer 0
    sif.out_ready_i = 1'b1;
    acc_clear();
    for (int i = 0; i < NSRC; i++) src_data[i] = rec(i, 100 + i);
    src_valid = '1;
    tick(1);
    src_valid = '0;
    tick(5);
    check("rr0_count", acc_cnt, 3);
    if (acc_src.size() == 3) begin
      check("rr0_first", acc_src[0], 0);
      check("rr0_second", acc_src[1], 1);
      check("rr0_third", acc_src[2], 2);
    end

    // Single record on source 1, latency and payload
    exp_rec      = rec(1, 5);
    src_data[1]  = exp_rec;
    src_valid[1] = 1'b1;
    tick(1);
    check("single_lat_n", sif.out_valid_o, 1'b0);
    tick(1);
    check("single_valid", sif.out_valid_o, 1'b1);
    check("single_src", sif.out_src_o, 1);
    check("single_tstart", sif.out_data_o.time_start, 16'd5);
    check("single_data", sif.out_data_o, exp_rec);
    src_valid[1] = 1'b0;
    tick(1);
    check("single_idle", sif.out_valid_o, 1'b0);

    // Round-robin from pointer 2
    acc_clear();
    for (int i = 0; i < NSRC; i++) src_data[i] = rec(i, 200 + i);
    src_valid = '1;
    tick(1);
    src_valid = '0;
    tick(5);
    check("rr2_count", acc_cnt, 3);
    if (acc_src.size() == 3) begin
      check("rr2_first", acc_src[0], 2);
      check("rr2_second", acc_src[1], 0);
      check("rr2_third", acc_src[2], 1);
    end

    // Level held six cycles is one record
    acc_clear();
    src_data[0]  = rec(0, 300);
    src_valid[0] = 1'b1;
    tick(6);
    src_valid[0] = 1'b0;
    tick(3);
    check("hold_count", acc_cnt, 1);
    check("hold_drop0", drop_count[0 +: CW], 0);

    // Level already high at re-enable is not captured
    acc_clear();
    enable       = 1'b0;
    src_valid[0] = 1'b1;
    tick(2);
    enable = 1'b1;
    tick(3);
    src_valid[0] = 1'b0;
    tick(3);
    check("enable_gate", acc_cnt, 0);

    // Backpressure: one held, four queued, one dropped
    sif.out_ready_i = 1'b0;
    acc_clear();
    for (int n = 0; n < 6; n++) pulse(2, 400 + n);
    check("bp_drop2", drop_count[2*CW +: CW], 1);
    check("bp_overflow", overflow, 1'b1);
    check("bp_held_src", sif.out_src_o, 2);
    check("bp_held_data", sif.out_data_o, rec(2, 400));
    // Drop coincident with clear: drop wins
    src_data[2]  = rec(2, 406);
    src_valid[2] = 1'b1;
    clr          = 1'b1;
    tick(1);
    clr          = 1'b0;
    src_valid[2] = 1'b0;
    check("clr_drop_cnt", drop_count[2*CW +: CW], 1);
    check("clr_drop_ovf", overflow, 1'b1);
    tick(1);
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
    check("clr_cnt", drop_count[2*CW +: CW], 0);
    check("clr_ovf", overflow, 1'b0);
    sif.out_ready_i = 1'b1;
    tick(8);
    check("bp_drain", acc_cnt, 5);

    // Full FIFO 0 pushed and popped at the same edge
    sif.out_ready_i = 1'b0;
    acc_clear();
    for (int n = 0; n < 5; n++) pulse(0, 500 + n);
    check("fpp_pre_drop", drop_count[0 +: CW], 0);
    sif.out_ready_i = 1'b1;
    src_data[0]     = rec(0, 505);
    src_valid[0]    = 1'b1;
    tick(1);
    src_valid[0] = 1'b0;
    check("fpp_drop", drop_count[0 +: CW], 0);
    check("fpp_ovf", overflow, 1'b0);
    tick(8);
    check("fpp_drain", acc_cnt, 6);

    // Asynchronous reset while presenting with three queued
    sif.out_ready_i = 1'b0;
    for (int n = 0; n < 4; n++) pulse(1, 600 + n);
    check("prerst_valid", sif.out_valid_o, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    check("rst_async_valid", sif.out_valid_o, 1'b0);
    check("rst_async_src", sif.out_src_o, 0);
    @(negedge clk);
    rst = 1'b0;
    acc_clear();
    sif.out_ready_i = 1'b1;
    tick(6);
    check("rst_no_stale", acc_cnt, 0);
    check("rst_idle", sif.out_valid_o, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
